// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: CHUNK bits per clock, LSB chunk first, through a
// registered carry, with a start/busy/done handshake.
module chunk_serial_adder #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

  generate
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
      $error("chunk_serial_adder: WIDTH must be >= 2 and a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_carry;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_res;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_ovf;

  logic [CHUNK:0]     w_add;
  logic [CHUNK-1:0]   w_s;
  logic               w_c;
  logic               w_c_msb;
  logic               w_last;
  logic [WIDTH-1:0]   w_res;

  assign w_add   = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]} + {{CHUNK{1'b0}}, r_carry};
  assign w_s     = w_add[CHUNK-1:0];
  assign w_c     = w_add[CHUNK];
  // Sum bit = a ^ b ^ carry-in, so the carry entering the top bit is recovered from it.
  assign w_c_msb = r_a[CHUNK-1] ^ r_b[CHUNK-1] ^ w_s[CHUNK-1];
  assign w_last  = (r_idx == LAST_IDX);

  always_comb begin
    w_res = r_res;
    w_res[r_idx*CHUNK +: CHUNK] = w_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
          end
        end
        S_RUN: begin
          r_res   <= w_res;
          r_a     <= r_a >> CHUNK;
          r_b     <= r_b >> CHUNK;
          r_carry <= w_c;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            r_sum  <= w_res;
            r_cout <= w_c;
            r_ovf  <= w_c ^ w_c_msb;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;
endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed and sweep bench for chunk_serial_adder: four WIDTH=8 instances
// (CHUNK 2,1,4,8) sharing inputs, plus a WIDTH=2/CHUNK=1 instance.
`timescale 1ns/1ps
module tb_chunk_serial_adder;
  localparam int NDUT = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, start2 = 1'b0, sub = 1'b0, cin = 1'b0;
  logic [7:0] a = 8'h00, b = 8'h00;
  logic [1:0] a2 = 2'b00, b2 = 2'b00;
  logic [7:0] sm [NDUT];
  logic       co [NDUT], ov [NDUT], dn [NDUT], by [NDUT];
  logic [1:0] sum2;
  logic       cout2, ovf2, done2, busy2;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CH = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 8;
    chunk_serial_adder #(.WIDTH(8), .CHUNK(CH)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
      .busy(by[g]), .done(dn[g]), .sum(sm[g]), .cout(co[g]), .ovf(ov[g]));
  end

  chunk_serial_adder #(.WIDTH(2), .CHUNK(1)) u_dut_w2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub), .a(a2), .b(b2), .cin(cin),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2));

  // Whole-word reference: returns {ovf, cout, sum} for a w-bit operation.
  function automatic logic [9:0] model(input int w, input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic su);
    logic [7:0] mask, yy;
    logic [8:0] full, low;
    logic       c0, co_m, cm;
    mask = 8'((9'd1 << w) - 9'd1);
    yy   = (su ? ~y : y) & mask;
    c0   = su ? 1'b1 : ci;
    full = {1'b0, x & mask} + {1'b0, yy} + {8'd0, c0};
    low  = {1'b0, x & (mask >> 1)} + {1'b0, yy & (mask >> 1)} + {8'd0, c0};
    co_m = full[w];
    cm   = low[w-1];
    return {co_m ^ cm, co_m, full[7:0] & mask};
  endfunction

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (by[0] !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", by[0]); end
    checks++; if (dn[0] !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", dn[0]); end
    checks++; if (sm[0] !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", sm[0]); end
    checks++; if (co[0] !== 1'b0 || ov[0] !== 1'b0) begin errors++; $display("FAIL reset_flags: got cout=%b ovf=%b want 0 0", co[0], ov[0]); end
    checks++; if (busy2 !== 1'b0 || sum2 !== 2'b00) begin errors++; $display("FAIL reset_w2: got busy=%b sum=%b want 0 00", busy2, sum2); end
    rst_n = 1'b1;
  endtask

  task automatic test_latency();
    logic eb, ed;
    @(negedge clk); a = 8'h5A; b = 8'hA5; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) @(negedge clk);
      eb = (k <= 4); ed = (k == 4);
      checks++; if (by[0] !== eb) begin errors++; $display("FAIL lat_busy[%0d]: got %b want %b", k, by[0], eb); end
      checks++; if (dn[0] !== ed) begin errors++; $display("FAIL lat_done[%0d]: got %b want %b", k, dn[0], ed); end
      if (k < 4) begin
        checks++; if (sm[0] !== 8'h00) begin errors++; $display("FAIL lat_partial[%0d]: got %h want 00", k, sm[0]); end
      end
      if (k == 4) begin
        checks++; if ({ov[0], co[0], sm[0]} !== {1'b0, 1'b0, 8'hFF})
          begin errors++; $display("FAIL lat_result: got ovf=%b cout=%b sum=%h want 0 0 ff", ov[0], co[0], sm[0]); end
      end
    end
  endtask

  task automatic test_add_sub();
    logic [7:0] ta [8], tbv [8], es [8];
    logic       tc [8], ts [8], ec [8], eo [8];
    int         n;
    ta  = '{8'hFF, 8'h7F, 8'h0F, 8'h80, 8'h05, 8'h80, 8'h05, 8'h10};
    tbv = '{8'h01, 8'h00, 8'h01, 8'h80, 8'h07, 8'h01, 8'h07, 8'h10};
    tc  = '{1'b0,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1 };
    ts  = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b1 };
    es  = '{8'h00, 8'h80, 8'h11, 8'h00, 8'hFE, 8'h7F, 8'hFE, 8'h00};
    ec  = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1 };
    eo  = '{1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b1,  1'b0,  1'b0 };
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); a = ta[i]; b = tbv[i]; cin = tc[i]; sub = ts[i]; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (dn[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (dn[0] !== 1'b1) begin errors++; $display("FAIL vec%0d_timeout: got no done want done", i); end
      else if ({ov[0], co[0], sm[0]} !== {eo[i], ec[i], es[i]}) begin
        errors++;
        $display("FAIL vec%0d: got ovf=%b cout=%b sum=%h want %b %b %h", i, ov[0], co[0], sm[0], eo[i], ec[i], es[i]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_hold_start();
    int nd, k1, k2;
    logic [7:0] s1, s2;
    logic idle5;
    @(negedge clk); a = 8'h11; b = 8'h22; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk); a = 8'h40; b = 8'h01;
    nd = 0; k1 = -1; k2 = -1; s1 = 8'h00; s2 = 8'h00; idle5 = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (dn[0] === 1'b1) begin
        if (nd == 0) begin k1 = k; s1 = sm[0]; end
        else if (nd == 1) begin k2 = k; s2 = sm[0]; end
        nd++;
      end
      if (k == 5) idle5 = (by[0] === 1'b0);
    end
    start = 1'b0;
    checks++; if (nd != 2) begin errors++; $display("FAIL hold_count: got %0d want 2", nd); end
    checks++; if (k1 != 4 || s1 !== 8'h33) begin errors++; $display("FAIL hold_first: got cyc=%0d sum=%h want 4 33", k1, s1); end
    checks++; if (k2 != 10 || s2 !== 8'h41) begin errors++; $display("FAIL hold_second: got cyc=%0d sum=%h want 10 41", k2, s2); end
    checks++; if (!idle5) begin errors++; $display("FAIL hold_idle_gap: got busy=1 want 0"); end
  endtask

  task automatic test_start_in_done();
    int n, nd;
    @(negedge clk); a = 8'h01; b = 8'h02; sub = 1'b0; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (dn[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (dn[0] !== 1'b1) begin errors++; $display("FAIL sid_timeout: got no done want done"); end
    a = 8'h10; b = 8'h10; start = 1'b1;
    @(negedge clk); start = 1'b0;
    checks++; if (by[0] !== 1'b0) begin errors++; $display("FAIL sid_busy: got %b want 0", by[0]); end
    nd = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (dn[0] === 1'b1) nd++; end
    checks++; if (nd != 0 || sm[0] !== 8'h03) begin errors++; $display("FAIL sid_ignored: got dones=%0d sum=%h want 0 03", nd, sm[0]); end
  endtask

  task automatic test_async_reset();
    int n, nd;
    @(negedge clk); a = 8'h21; b = 8'h10; sub = 1'b0; cin = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(posedge clk); #2 rst_n = 1'b0;
    #1;
    checks++; if ({by[0], dn[0], co[0], ov[0]} !== 4'b0000) begin errors++; $display("FAIL arst_ctrl: got busy=%b done=%b cout=%b ovf=%b want 0000", by[0], dn[0], co[0], ov[0]); end
    checks++; if (sm[0] !== 8'h00) begin errors++; $display("FAIL arst_sum: got %h want 00", sm[0]); end
    @(negedge clk); rst_n = 1'b1;
    nd = 0;
    for (int k = 0; k < 6; k++) begin @(negedge clk); if (dn[0] === 1'b1) nd++; end
    checks++; if (nd != 0) begin errors++; $display("FAIL arst_nodone: got %0d want 0", nd); end
    a = 8'h03; b = 8'h04; cin = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (dn[0] !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    checks++; if (dn[0] !== 1'b1 || sm[0] !== 8'h07) begin errors++; $display("FAIL arst_fresh: got done=%b sum=%h want 1 07", dn[0], sm[0]); end
    @(negedge clk);
  endtask

  task automatic test_sweep_w2();
    logic [9:0] e;
    int nd;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      a2 = i[1:0]; b2 = i[3:2]; cin = i[4]; sub = i[5]; start2 = 1'b1;
      e = model(2, {6'd0, i[1:0]}, {6'd0, i[3:2]}, i[4], i[5]);
      @(negedge clk); start2 = 1'b0;
      nd = 0;
      for (int k = 0; k < 4; k++) begin @(negedge clk); if (done2 === 1'b1) nd++; end
      checks++;
      if (nd != 1 || {ovf2, cout2, sum2} !== {e[9], e[8], e[1:0]}) begin
        errors++;
        $display("FAIL w2[%0d]: got dones=%0d ovf=%b cout=%b sum=%b want 1 %b %b %b", i, nd, ovf2, cout2, sum2, e[9], e[8], e[1:0]);
      end
    end
  endtask

  task automatic test_sweep_w8();
    logic [9:0] e;
    int nd [NDUT];
    start = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom); sub = 1'($urandom);
      e = model(8, a, b, cin, sub);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      for (int g = 0; g < NDUT; g++) nd[g] = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        for (int g = 0; g < NDUT; g++) if (dn[g] === 1'b1) nd[g]++;
      end
      for (int g = 0; g < NDUT; g++) begin
        checks++;
        if (nd[g] != 1 || {ov[g], co[g], sm[g]} !== e) begin
          errors++;
          $display("FAIL w8_dut%0d[%0d]: got dones=%0d ovf=%b cout=%b sum=%h want 1 %b %b %h",
                   g, i, nd[g], ov[g], co[g], sm[g], e[9], e[8], e[7:0]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_add_sub();
    test_hold_start();
    test_start_in_done();
    test_async_reset();
    test_sweep_w2();
    test_sweep_w8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
